// File: rtl/vermitypes_pkg.sv
// Shared Vermicel types: default register-file geometry and the
// write-back port bundle used between execution units and the file.
package vermitypes_pkg;

  localparam int VM_SIZE  = 32;
  localparam int VM_WIDTH = 32;
  localparam int VM_IDX   = $clog2(VM_SIZE);

  typedef logic [VM_IDX-1:0]   regidx_t;
  typedef logic [VM_WIDTH-1:0] word_t;

  typedef struct packed {
    logic    valid;
    regidx_t rd;
    word_t   data;
  } wb_port_t;

endpackage

// File: rtl/vergister_bypass_mux.sv
// One read port: stored value, optionally overridden by the
// highest-numbered matching write-back, with register 0 forced to zero.
module vergister_bypass_mux
  import vermitypes_pkg::*;
#(
  parameter int WIDTH       = VM_WIDTH,
  parameter int IDX         = VM_IDX,
  parameter int WRITE_PORTS = 2,
  parameter int ZERO_REG    = 1,
  parameter int BYPASS      = 1
) (
  input  logic [IDX-1:0]               rs_i,
  input  logic [WIDTH-1:0]             stored_i,
  input  logic [WRITE_PORTS-1:0]       wb_valid_i,
  input  logic [WRITE_PORTS*IDX-1:0]   wb_rd_i,
  input  logic [WRITE_PORTS*WIDTH-1:0] wb_data_i,
  output logic [WIDTH-1:0]             xs_o
);

  always_comb begin
    xs_o = stored_i;
    if (BYPASS != 0) begin
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (wb_valid_i[p] && wb_rd_i[p*IDX +: IDX] == rs_i)
          xs_o = wb_data_i[p*WIDTH +: WIDTH];
      end
    end
    if (ZERO_REG != 0 && rs_i == '0)
      xs_o = '0;
  end

endmodule

// File: rtl/vergister_scoreboard.sv
// Register file with multi-port write-back, busy scoreboard for
// in-flight destinations, optional bypass and hard-wired zero register.
module vergister_scoreboard
  import vermitypes_pkg::*;
#(
  parameter int SIZE        = VM_SIZE,
  parameter int WIDTH       = VM_WIDTH,
  parameter int WRITE_PORTS = 2,
  parameter int ZERO_REG    = 1,
  parameter int BYPASS      = 1,
  parameter int IDX         = $clog2(SIZE),
  parameter int CW          = $clog2(SIZE+1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         issue_valid,
  input  logic                         issue_has_rd,
  input  logic [IDX-1:0]               issue_rd,
  input  logic [IDX-1:0]               rs1,
  input  logic [IDX-1:0]               rs2,
  output logic [WIDTH-1:0]             xs1,
  output logic [WIDTH-1:0]             xs2,
  output logic                         stall,
  input  logic [WRITE_PORTS-1:0]       wb_valid,
  input  logic [WRITE_PORTS*IDX-1:0]   wb_rd,
  input  logic [WRITE_PORTS*WIDTH-1:0] wb_data,
  input  logic                         flush,
  output logic [CW-1:0]                busy_count
);

  logic [WIDTH-1:0]       x_q [SIZE];
  logic [SIZE-1:0]        busy_q, busy_d;
  logic [SIZE-1:0]        busy_clr, busy_eff;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WRITE_PORTS-1:0] wr_en;
  logic                   fire;

  always_comb begin
    busy_clr = '0;
    wr_en    = '0;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      if (wb_valid[p]) begin
        busy_clr[wb_rd[p*IDX +: IDX]] = 1'b1;
        wr_en[p] = !(ZERO_REG != 0 && wb_rd[p*IDX +: IDX] == '0);
      end
    end
  end

  assign busy_eff = (BYPASS != 0) ? (busy_q & ~busy_clr) : busy_q;

  assign stall = issue_valid &
                 (busy_eff[rs1] | busy_eff[rs2] |
                  (issue_has_rd & busy_eff[issue_rd]));

  assign fire = issue_valid & ~stall & ~flush;

  // Set after clear: the issuing instruction is newer than the retiring one.
  always_comb begin
    busy_d = flush ? '0 : (busy_q & ~busy_clr);
    if (fire && issue_has_rd &&
        !(ZERO_REG != 0 && issue_rd == '0))
      busy_d[issue_rd] = 1'b1;
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < SIZE; i++)
      cnt_d = cnt_d + CW'(busy_d[i]);
  end

  // Later ports overwrite earlier ones, so the highest index wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SIZE; i++)
        x_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (wr_en[p])
          x_q[wb_rd[p*IDX +: IDX]] <= wb_data[p*WIDTH +: WIDTH];
      end
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_count = cnt_q;

  vergister_bypass_mux #(
    .WIDTH(WIDTH), .IDX(IDX), .WRITE_PORTS(WRITE_PORTS),
    .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_mux1 (
    .rs_i(rs1), .stored_i(x_q[rs1]),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .xs_o(xs1)
  );

  vergister_bypass_mux #(
    .WIDTH(WIDTH), .IDX(IDX), .WRITE_PORTS(WRITE_PORTS),
    .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_mux2 (
    .rs_i(rs2), .stored_i(x_q[rs2]),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .xs_o(xs2)
  );

endmodule
